// File: rtl/lcd_char_writer.sv
// HD44780 8-bit write-only driver: power-up init, char writes, cursor and wrap.
// Optional macro LCD_TWO_LINE_EN selects 2-line function set and line wrap.
module lcd_char_writer #(
    parameter int T_PWR = 750000,
    parameter int T_EN  = 12,
    parameter int T_CMD = 2500,
    parameter int T_CLR = 100000,
    parameter int COLS  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_char,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_clear,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic [5:0] o_col,
    output logic       o_line
);

    typedef enum logic [3:0] {
        S_PWR, S_FUNC, S_DISP, S_ICLR, S_ENTRY,
        S_IDLE, S_WCHR, S_WADR, S_WCLR, S_DROP
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP, P_PULSE, P_HOLD, P_WAIT
    } phase_t;

`ifdef LCD_TWO_LINE_EN
    localparam logic [7:0] FSET = 8'h38;
`else
    localparam logic [7:0] FSET = 8'h30;
`endif

    state_t      state_q;
    phase_t      ph_q;
    logic [31:0] cnt_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        e_q;
    logic [5:0]  col_q;
    logic        line_q;

    logic [31:0] cnt_d;
    logic [31:0] wait_last;
    logic        printable;
    logic [7:0]  wrap_addr;
    logic        line_d;

    assign cnt_d     = cnt_q + 32'd1;
    assign printable = (i_char >= 8'h20) && (i_char <= 8'h7E);

    // Clear is the only command that needs the long settle time.
    assign wait_last = (!rs_q && data_q == 8'h01) ? 32'(T_CLR - 1)
                                                  : 32'(T_CMD - 1);

`ifdef LCD_TWO_LINE_EN
    assign wrap_addr = line_q ? 8'h80 : 8'hC0;
    assign line_d    = ~line_q;
`else
    assign wrap_addr = 8'h80;
    assign line_d    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_PWR;
            ph_q    <= P_SETUP;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            e_q     <= 1'b0;
            col_q   <= '0;
            line_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_PWR: begin
                    if (cnt_q == 32'(T_PWR - 1)) begin
                        cnt_q   <= '0;
                        ph_q    <= P_SETUP;
                        state_q <= S_FUNC;
                        rs_q    <= 1'b0;
                        data_q  <= FSET;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_IDLE: begin
                    if (i_clear) begin
                        state_q <= S_WCLR;
                        rs_q    <= 1'b0;
                        data_q  <= 8'h01;
                    end else if (i_valid) begin
                        if (printable) begin
                            state_q <= S_WCHR;
                            rs_q    <= 1'b1;
                            data_q  <= i_char;
                        end else begin
                            state_q <= S_DROP;
                        end
                    end
                end
                S_DROP: state_q <= S_IDLE;
                default: begin
                    unique case (ph_q)
                        P_SETUP: begin
                            ph_q  <= P_PULSE;
                            e_q   <= 1'b1;
                            cnt_q <= '0;
                        end
                        P_PULSE: begin
                            if (cnt_q == 32'(T_EN - 1)) begin
                                ph_q <= P_HOLD;
                                e_q  <= 1'b0;
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                        P_HOLD: begin
                            ph_q  <= P_WAIT;
                            cnt_q <= '0;
                        end
                        P_WAIT: begin
                            if (cnt_q == wait_last) begin
                                cnt_q <= '0;
                                ph_q  <= P_SETUP;
                                case (state_q)
                                    S_FUNC: begin
                                        state_q <= S_DISP;
                                        data_q  <= 8'h0C;
                                    end
                                    S_DISP: begin
                                        state_q <= S_ICLR;
                                        data_q  <= 8'h01;
                                    end
                                    S_ICLR: begin
                                        state_q <= S_ENTRY;
                                        data_q  <= 8'h06;
                                    end
                                    // Last column: reposition before more input.
                                    S_WCHR: begin
                                        if (col_q == 6'(COLS - 1)) begin
                                            state_q <= S_WADR;
                                            rs_q    <= 1'b0;
                                            data_q  <= wrap_addr;
                                        end else begin
                                            state_q <= S_IDLE;
                                            col_q   <= col_q + 6'd1;
                                        end
                                    end
                                    S_WADR: begin
                                        state_q <= S_IDLE;
                                        col_q   <= '0;
                                        line_q  <= line_d;
                                    end
                                    S_WCLR: begin
                                        state_q <= S_IDLE;
                                        col_q   <= '0;
                                        line_q  <= 1'b0;
                                    end
                                    default: state_q <= S_IDLE;
                                endcase
                            end else begin
                                cnt_q <= cnt_d;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign o_ready  = (state_q == S_IDLE) && !i_clear;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = e_q;
    assign lcd_data = data_q;
    assign o_col    = col_q;
    assign o_line   = line_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with short timing parameters.
`timescale 1ns/1ps
module tb_lcd_char_writer;

    localparam int T_PWR = 20;
    localparam int T_EN  = 2;
    localparam int T_CMD = 4;
    localparam int T_CLR = 8;
    localparam int COLS  = 16;
    localparam int INIT_CYC = T_PWR + 4 * (1 + T_EN + 1) + 3 * T_CMD + T_CLR;

`ifdef LCD_TWO_LINE_EN
    localparam logic [7:0] FSET  = 8'h38;
    localparam logic [7:0] ADDR1 = 8'hC0;
    localparam logic       LINE1 = 1'b1;
`else
    localparam logic [7:0] FSET  = 8'h30;
    localparam logic [7:0] ADDR1 = 8'h80;
    localparam logic       LINE1 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_char;
    logic       i_valid;
    logic       o_ready;
    logic       i_clear;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic [5:0] o_col;
    logic       o_line;

    always #5 clk = ~clk;

    lcd_char_writer #(
        .T_PWR(T_PWR), .T_EN(T_EN), .T_CMD(T_CMD),
        .T_CLR(T_CLR), .COLS(COLS)
    ) dut (
        .clk(clk), .rst(rst),
        .i_char(i_char), .i_valid(i_valid), .o_ready(o_ready),
        .i_clear(i_clear),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data), .o_col(o_col), .o_line(o_line)
    );

    int checks = 0;
    int errors = 0;

    logic       q_rs[$];
    logic [7:0] q_data[$];
    int         q_w[$];

    int         ew = 0;
    logic       cap_rs = 1'b0;
    logic [7:0] cap_d = 8'h00;
    logic       unstable = 1'b0;

    // Pulse logger; width 999 marks rs/data moving while e is high.
    always @(negedge clk) begin
        if (rst) begin
            ew = 0;
            unstable = 1'b0;
        end else if (lcd_e) begin
            if (ew == 0) begin
                cap_rs = lcd_rs;
                cap_d  = lcd_data;
            end else if (lcd_rs !== cap_rs || lcd_data !== cap_d) begin
                unstable = 1'b1;
            end
            ew++;
        end else if (ew != 0) begin
            q_rs.push_back(cap_rs);
            q_data.push_back(cap_d);
            q_w.push_back(unstable ? 999 : ew);
            ew = 0;
            unstable = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qclear();
        q_rs.delete();
        q_data.delete();
        q_w.delete();
    endtask

    task automatic chk_pulse(input string tag, input logic rs,
                             input logic [7:0] d);
        logic [31:0] obs;
        logic        prs;
        logic [7:0]  pd;
        int          pw;
        if (q_rs.size() == 0) begin
            obs = 32'hFFFF_FFFF;
        end else begin
            prs = q_rs.pop_front();
            pd  = q_data.pop_front();
            pw  = q_w.pop_front();
            obs = {16'(pw), 7'd0, prs, pd};
        end
        chk(tag, obs, {16'(T_EN), 7'd0, rs, d});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end while (!o_ready && n < 300);
    endtask

    task automatic send(input logic [7:0] ch, input logic clr);
        i_char  = ch;
        i_valid = 1'b1;
        i_clear = clr;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_char  = 8'h00;
    endtask

    task automatic check_init(input string tag);
        int n;
        wait_ready(n);
        chk({tag, "_rdy_cycle"}, 32'(n), 32'(INIT_CYC));
        chk_pulse({tag, "_fset"}, 1'b0, FSET);
        chk_pulse({tag, "_disp"}, 1'b0, 8'h0C);
        chk_pulse({tag, "_clr"}, 1'b0, 8'h01);
        chk_pulse({tag, "_entry"}, 1'b0, 8'h06);
        chk({tag, "_extra"}, 32'(q_rs.size()), 32'd0);
        chk({tag, "_col"}, 32'(o_col), 32'd0);
    endtask

    task automatic put(input string tag, input logic [7:0] ch,
                       input int cyc);
        int n;
        send(ch, 1'b0);
        wait_ready(n);
        chk({tag, "_lat"}, 32'(n), 32'(cyc));
    endtask

    initial begin
        int n;
        i_char  = 8'h00;
        i_valid = 1'b0;
        i_clear = 1'b0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_col", 32'(o_col), 32'd0);
        chk("rst_line", 32'(o_line), 32'd0);
        qclear();
        rst = 1'b0;
        check_init("init");

        put("c35", 8'h35, 8);
        chk_pulse("c35_pulse", 1'b1, 8'h35);
        chk("c35_col", 32'(o_col), 32'd1);
        chk("c35_line", 32'(o_line), 32'd0);

        send(8'h39, 1'b1);
        wait_ready(n);
        chk("clr_lat", 32'(n), 32'd12);
        chk_pulse("clr_pulse", 1'b0, 8'h01);
        chk("clr_nochar", 32'(q_rs.size()), 32'd0);
        chk("clr_col", 32'(o_col), 32'd0);
        chk("clr_line", 32'(o_line), 32'd0);

        put("c20", 8'h20, 8);
        chk_pulse("c20_pulse", 1'b1, 8'h20);
        put("c7e", 8'h7E, 8);
        chk_pulse("c7e_pulse", 1'b1, 8'h7E);
        put("c1f", 8'h1F, 1);
        put("c7f", 8'h7F, 1);
        put("c0a", 8'h0A, 1);
        chk("drop_nopulse", 32'(q_rs.size()), 32'd0);
        chk("drop_col", 32'(o_col), 32'd2);
        chk("rw_low", 32'(lcd_rw), 32'd0);

        send(8'h00, 1'b1);
        wait_ready(n);
        chk("clr2_lat", 32'(n), 32'd12);
        chk_pulse("clr2_pulse", 1'b0, 8'h01);
        chk("clr2_col", 32'(o_col), 32'd0);

        for (int i = 0; i < COLS; i++) begin
            put("wrapA", 8'h41, (i == COLS - 1) ? 16 : 8);
            if (i == COLS - 2) chk("wrapA_col15", 32'(o_col), 32'(COLS - 1));
        end
        for (int i = 0; i < COLS; i++) chk_pulse("wrapA_char", 1'b1, 8'h41);
        chk_pulse("wrapA_addr", 1'b0, ADDR1);
        chk("wrapA_col", 32'(o_col), 32'd0);
        chk("wrapA_line", 32'(o_line), 32'(LINE1));

        for (int i = 0; i < COLS; i++) begin
            put("wrapB", 8'h42, (i == COLS - 1) ? 16 : 8);
        end
        for (int i = 0; i < COLS; i++) chk_pulse("wrapB_char", 1'b1, 8'h42);
        chk_pulse("wrapB_addr", 1'b0, 8'h80);
        chk("wrapB_col", 32'(o_col), 32'd0);
        chk("wrapB_line", 32'(o_line), 32'd0);

        put("c31", 8'h31, 8);
        chk("c31_col", 32'(o_col), 32'd1);
        send(8'h43, 1'b0);
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_e_seen", 32'(lcd_e), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_e", 32'(lcd_e), 32'd0);
        chk("mid_rst_ready", 32'(o_ready), 32'd0);
        chk("mid_rst_col", 32'(o_col), 32'd0);
        repeat (2) @(negedge clk);
        qclear();
        rst = 1'b0;
        check_init("reinit");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
